pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the in-order RISC-V core. It owns the per-stage valid bits and every pipeline-register load/bubble decision, and adds external-stall support, a halt-drain state machine and saturating performance counters. Today the datapath scatters these decisions across its register `always` blocks. The datapath instantiates one `pipe_ctrl` and drives each pipeline register from `reg_en`/`reg_clr`.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_sat_counter.sv | 19 +
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PS_RUN    = 2'd0,
    PS_DRAIN  = 2'd1,
    PS_HALTED = 2'd2
  } pipe_state_e;

  localparam logic [6:0] HALT_OPCODE = 7'h7F;

  localparam int unsigned STAGES_MIN = 3;
  localparam int unsigned STAGES_MAX = 8;
  localparam int unsigned CNT_W_MIN  = 8;
  localparam int unsigned CNT_W_MAX  = 64;

  // Mask covering the n lowest (youngest) pipeline registers.
  function automatic logic [STAGES_MAX-2:0] low_mask(int unsigned n);
    logic [STAGES_MAX-2:0] m;
    m = '0;
    for (int unsigned i = 0; i < STAGES_MAX - 1; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage valid bits, register load/bubble decisions,
// external stall, halt-drain sequencing and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES      = 5,
  parameter int unsigned FLUSH_STAGE = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        id_opcode,
  input  logic              load_use,
  input  logic              redirect,
  input  logic              stall_ext,
  output logic              pc_en,
  output logic [STAGES-2:0] reg_en,
  output logic [STAGES-2:0] reg_clr,
  output logic [STAGES-2:0] valid,
  output logic [1:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned NREG = STAGES - 1;
  localparam logic [STAGES_MAX-2:0] FLUSH_MASK_FULL = low_mask(FLUSH_STAGE);
  localparam logic [NREG-1:0] FLUSH_MASK = FLUSH_MASK_FULL[NREG-1:0];

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pipe_ctrl: STAGES out of range");
  end
  if (FLUSH_STAGE < 1 || FLUSH_STAGE > NREG - 1) begin : g_bad_flush
    $error("pipe_ctrl: FLUSH_STAGE out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("pipe_ctrl: CNT_W out of range");
  end

  pipe_state_e     state_q, state_nxt;
  logic [NREG-1:0] valid_q, valid_nxt;
  logic            drain_step;
  logic            bubble_en, flush_en, cycle_en, retire_en;

  // Load/bubble decision, valid shift and next state.
  always_comb begin
    pc_en      = 1'b0;
    reg_en     = '0;
    reg_clr    = '0;
    state_nxt  = state_q;
    drain_step = 1'b0;
    bubble_en  = 1'b0;
    flush_en   = 1'b0;

    if (!reset) begin
      reg_en  = '1;
      reg_clr = '1;
    end else if (state_q == PS_HALTED || stall_ext) begin
      // frozen: nothing loads
    end else if (redirect) begin
      pc_en     = 1'b1;
      reg_en    = '1;
      reg_clr   = FLUSH_MASK;
      flush_en  = 1'b1;
      state_nxt = PS_RUN;
    end else if (state_q == PS_RUN && valid_q[0] && id_opcode == HALT_OPCODE) begin
      // squash the halt in IF/ID and its successor so it never executes
      reg_en       = '1;
      reg_clr[1:0] = 2'b11;
      state_nxt    = PS_DRAIN;
    end else if (state_q == PS_RUN && load_use) begin
      reg_en     = '1;
      reg_en[0]  = 1'b0;
      reg_clr[1] = 1'b1;
      bubble_en  = 1'b1;
    end else if (state_q == PS_RUN) begin
      pc_en  = 1'b1;
      reg_en = '1;
    end else begin
      reg_en     = '1;
      reg_clr[0] = 1'b1;
      drain_step = 1'b1;
    end

    valid_nxt = valid_q;
    if (reg_en[0]) valid_nxt[0] = ~reg_clr[0];
    for (int unsigned k = 1; k < NREG; k++) begin
      if (reg_en[k]) valid_nxt[k] = reg_clr[k] ? 1'b0 : valid_q[k-1];
    end

    if (drain_step && valid_nxt == '0) state_nxt = PS_HALTED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      state_q <= PS_RUN;
      halted  <= 1'b0;
    end else begin
      valid_q <= valid_nxt;
      state_q <= state_nxt;
      halted  <= (state_nxt == PS_HALTED);
    end
  end

  assign valid     = valid_q;
  assign state     = state_q;
  assign cycle_en  = (state_q != PS_HALTED);
  assign retire_en = valid_q[NREG-1] & ~stall_ext;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .en(cycle_en), .count(cycle_cnt)
  );
  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .reset(reset), .en(retire_en), .count(retire_cnt)
  );
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset(reset), .en(bubble_en), .count(bubble_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .en(flush_en), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: occupancy-mask model checked every cycle plus directed scenarios.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned STAGES      = 5;
  localparam int unsigned NREG        = 4;
  localparam int unsigned FLUSH_STAGE = 2;
  localparam logic [6:0]  OP_NOP      = 7'h13;
  localparam logic [6:0]  OP_HALT     = 7'h7F;
  localparam logic [3:0]  FMASK       = 4'((1 << FLUSH_STAGE) - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] id_opcode = OP_NOP;
  logic       load_use = 1'b0, redirect = 1'b0, stall_ext = 1'b0;

  logic        pc_en, halted, pc_en8, halted8;
  logic [3:0]  reg_en, reg_clr, valid, reg_en8, reg_clr8, valid8;
  logic [1:0]  state, state8;
  logic [31:0] cyc, ret, bub, flu;
  logic [7:0]  cyc8, ret8, bub8, flu8;

  pipe_ctrl #(.STAGES(STAGES), .FLUSH_STAGE(FLUSH_STAGE), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .load_use(load_use),
    .redirect(redirect), .stall_ext(stall_ext), .pc_en(pc_en), .reg_en(reg_en),
    .reg_clr(reg_clr), .valid(valid), .state(state), .halted(halted),
    .cycle_cnt(cyc), .retire_cnt(ret), .bubble_cnt(bub), .flush_cnt(flu)
  );

  pipe_ctrl #(.STAGES(STAGES), .FLUSH_STAGE(FLUSH_STAGE), .CNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .load_use(load_use),
    .redirect(redirect), .stall_ext(stall_ext), .pc_en(pc_en8), .reg_en(reg_en8),
    .reg_clr(reg_clr8), .valid(valid8), .state(state8), .halted(halted8),
    .cycle_cnt(cyc8), .retire_cnt(ret8), .bubble_cnt(bub8), .flush_cnt(flu8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input longint unsigned c, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (c > lim) ? lim : c;
  endfunction

  // Model: occupancy mask mv (bit k = register k holds a live instruction).
  logic [3:0]      mv = 4'b0;
  pipe_state_e     ms = PS_RUN;
  longint unsigned mcyc = 0, mret = 0, mbub = 0, mflu = 0;

  always @(negedge clk) begin
    logic        e_pc, f_bub, f_flu;
    logic [3:0]  e_en, e_clr, nv;
    pipe_state_e ns;
    if (!reset) begin
      mv = 4'b0; ms = PS_RUN; mcyc = 0; mret = 0; mbub = 0; mflu = 0;
      e_pc = 1'b0; e_en = 4'hF; e_clr = 4'hF; nv = 4'b0; ns = PS_RUN;
      f_bub = 1'b0; f_flu = 1'b0;
    end else begin
      e_pc = 1'b0; e_en = 4'h0; e_clr = 4'h0; nv = mv; ns = ms;
      f_bub = 1'b0; f_flu = 1'b0;
      if (ms == PS_HALTED || stall_ext) begin
        // nothing moves
      end else if (redirect) begin
        e_pc = 1'b1; e_en = 4'hF; e_clr = FMASK;
        nv = (mv << 1) & ~FMASK; ns = PS_RUN; f_flu = 1'b1;
      end else if (ms == PS_RUN && mv[0] && id_opcode == OP_HALT) begin
        e_en = 4'hF; e_clr = 4'b0011; nv = (mv << 1) & 4'b1100; ns = PS_DRAIN;
      end else if (ms == PS_RUN && load_use) begin
        e_en = 4'b1110; e_clr = 4'b0010;
        nv = ((mv << 1) & 4'b1100) | (mv & 4'b0001); f_bub = 1'b1;
      end else if (ms == PS_RUN) begin
        e_pc = 1'b1; e_en = 4'hF; nv = (mv << 1) | 4'b0001;
      end else begin
        e_en = 4'hF; e_clr = 4'b0001; nv = (mv << 1) & 4'b1110;
        if (nv == 4'b0) ns = PS_HALTED;
      end
    end
    chk("pc_en", 64'(pc_en), 64'(e_pc));
    chk("reg_en", 64'(reg_en), 64'(e_en));
    chk("reg_clr", 64'(reg_clr & reg_en), 64'(e_clr & e_en));
    chk("valid", 64'(valid), 64'(mv));
    chk("state", 64'(state), 64'(ms));
    chk("halted", 64'(halted), 64'(ms == PS_HALTED));
    chk("cycle_cnt", 64'(cyc), sat(mcyc, 32));
    chk("retire_cnt", 64'(ret), sat(mret, 32));
    chk("bubble_cnt", 64'(bub), sat(mbub, 32));
    chk("flush_cnt", 64'(flu), sat(mflu, 32));
    chk("w8_ctrl", 64'({pc_en8, reg_en8, reg_clr8 & reg_en8, valid8, state8, halted8}),
        64'({e_pc, e_en, e_clr & e_en, mv, ms, ms == PS_HALTED}));
    chk("w8_cycle_cnt", 64'(cyc8), sat(mcyc, 8));
    chk("w8_retire_cnt", 64'(ret8), sat(mret, 8));
    chk("w8_bubble_cnt", 64'(bub8), sat(mbub, 8));
    chk("w8_flush_cnt", 64'(flu8), sat(mflu, 8));
    if (reset) begin
      if (ms != PS_HALTED) mcyc++;
      if (mv[3] && !stall_ext) mret++;
      if (f_bub) mbub++;
      if (f_flu) mflu++;
      mv = nv;
      ms = ns;
    end
  end

  task automatic set_in(input logic lu, input logic rd, input logic st, input logic [6:0] op);
    load_use = lu; redirect = rd; stall_ext = st; id_opcode = op;
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic reset_fill();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    reset = 1'b0;
    edge_();
    reset = 1'b1;
    repeat (4) edge_();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fill [6];
    fill = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};

    // Reset, then six free-running cycles
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_pc_en", 64'(pc_en), 64'd0);
    chk("lit_rst_reg_en", 64'(reg_en), 64'hF);
    chk("lit_rst_reg_clr", 64'(reg_clr), 64'hF);
    chk("lit_rst_valid", 64'(valid), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge_();
      chk("lit_fill_valid", 64'(valid), 64'(fill[i]));
    end
    chk("lit_fill_retire", 64'(ret), 64'd2);
    chk("lit_fill_cycle", 64'(cyc), 64'd6);

    // Load-use bubble
    reset_fill();
    set_in(1'b1, 1'b0, 1'b0, OP_NOP);
    mid();
    chk("lit_lu_pc_en", 64'(pc_en), 64'd0);
    chk("lit_lu_reg_en0", 64'(reg_en[0]), 64'd0);
    chk("lit_lu_reg_clr1", 64'(reg_clr[1]), 64'd1);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_lu_valid", 64'(valid), 64'b1101);
    chk("lit_lu_bubble", 64'(bub), 64'd1);

    // Redirect wins over load-use
    reset_fill();
    set_in(1'b1, 1'b1, 1'b0, OP_NOP);
    mid();
    chk("lit_rd_pc_en", 64'(pc_en), 64'd1);
    chk("lit_rd_reg_clr", 64'(reg_clr), 64'b0011);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_rd_valid", 64'(valid), 64'b1100);
    chk("lit_rd_flush", 64'(flu), 64'd1);
    chk("lit_rd_bubble", 64'(bub), 64'd0);

    // Halt drains to HALTED; redirect afterwards is ignored; async reset exits
    reset_fill();
    set_in(1'b0, 1'b0, 1'b0, OP_HALT);
    mid();
    chk("lit_halt_pc_en", 64'(pc_en), 64'd0);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_halt_valid1", 64'(valid), 64'b1100);
    chk("lit_halt_state1", 64'(state), 64'(PS_DRAIN));
    edge_();
    chk("lit_halt_valid2", 64'(valid), 64'b1000);
    chk("lit_halt_halted2", 64'(halted), 64'd0);
    edge_();
    chk("lit_halt_valid3", 64'(valid), 64'b0000);
    chk("lit_halt_halted3", 64'(halted), 64'd1);
    chk("lit_halt_cycle", 64'(cyc), 64'd7);
    chk("lit_halt_retire", 64'(ret), 64'd3);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, OP_NOP);
      mid();
      chk("lit_halted_pc_en", 64'(pc_en), 64'd0);
      chk("lit_halted_reg_en", 64'(reg_en), 64'd0);
      edge_();
    end
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_halted_flush", 64'(flu), 64'd0);
    chk("lit_halted_cycle", 64'(cyc), 64'd7);
    chk("lit_halted_state", 64'(state), 64'(PS_HALTED));
    #2 reset = 1'b0;
    #1;
    chk("lit_hrst_state", 64'(state), 64'(PS_RUN));
    chk("lit_hrst_halted", 64'(halted), 64'd0);
    chk("lit_hrst_cycle", 64'(cyc), 64'd0);
    edge_();
    reset = 1'b1;

    // Redirect during DRAIN cancels the halt
    reset_fill();
    set_in(1'b0, 1'b0, 1'b0, OP_HALT);
    edge_();
    chk("lit_cancel_state1", 64'(state), 64'(PS_DRAIN));
    set_in(1'b0, 1'b1, 1'b0, OP_NOP);
    mid();
    chk("lit_cancel_pc_en", 64'(pc_en), 64'd1);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_cancel_state2", 64'(state), 64'(PS_RUN));
    chk("lit_cancel_valid", 64'(valid), 64'b1000);
    repeat (4) edge_();
    chk("lit_cancel_halted", 64'(halted), 64'd0);
    chk("lit_cancel_refill", 64'(valid), 64'b1111);

    // Async reset mid-DRAIN
    set_in(1'b0, 1'b0, 1'b0, OP_HALT);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    #2 reset = 1'b0;
    #1;
    chk("lit_drst_state", 64'(state), 64'(PS_RUN));
    chk("lit_drst_valid", 64'(valid), 64'd0);
    edge_();
    reset = 1'b1;

    // External stall stretches the drain
    reset_fill();
    set_in(1'b0, 1'b0, 1'b0, OP_HALT);
    edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    edge_();
    chk("lit_stall_pre_cycle", 64'(cyc), 64'd6);
    chk("lit_stall_pre_retire", 64'(ret), 64'd2);
    set_in(1'b0, 1'b0, 1'b1, OP_NOP);
    repeat (3) edge_();
    set_in(1'b0, 1'b0, 1'b0, OP_NOP);
    chk("lit_stall_valid", 64'(valid), 64'b1000);
    chk("lit_stall_retire", 64'(ret), 64'd2);
    chk("lit_stall_cycle", 64'(cyc), 64'd9);
    chk("lit_stall_halted_pre", 64'(halted), 64'd0);
    edge_();
    chk("lit_stall_halted", 64'(halted), 64'd1);
    chk("lit_stall_retire_end", 64'(ret), 64'd3);

    // Long free run: the 8-bit counters saturate
    reset_fill();
    repeat (300) edge_();
    chk("lit_sat_cycle32", 64'(cyc), 64'd304);
    chk("lit_sat_retire32", 64'(ret), 64'd300);
    chk("lit_sat_cycle8", 64'(cyc8), 64'd255);
    chk("lit_sat_retire8", 64'(ret8), 64'd255);

    mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
